// File: rtl/fifo_sync_flex.sv
// Single-clock parametrised FIFO with wrap-bit pointers, programmable almost-full/almost-empty
// thresholds and a selectable registered or first-word-fall-through read port.
module fifo_sync_flex #(
  parameter int G_WIDTH  = 8,
  parameter int G_DEPTH  = 4,
  parameter int G_AFULL  = 14,
  parameter int G_AEMPTY = 2,
  parameter int G_FWFT   = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr,
  input  logic [G_WIDTH-1:0] i_data,
  input  logic               i_rd,
  output logic [G_WIDTH-1:0] o_data,
  output logic               o_valid,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_almost_full,
  output logic               o_almost_empty,
  output logic [G_DEPTH:0]   o_fill_level,
  output logic               o_overflow,
  output logic               o_underflow
);

  localparam int              C_CAP    = 2 ** G_DEPTH;
  localparam logic [G_DEPTH:0] C_CAP_V   = (G_DEPTH + 1)'(C_CAP);
  localparam logic [G_DEPTH:0] C_AFULL_V = (G_DEPTH + 1)'(G_AFULL);
  localparam logic [G_DEPTH:0] C_AEMPT_V = (G_DEPTH + 1)'(G_AEMPTY);
  localparam logic [G_DEPTH:0] C_ZERO    = {(G_DEPTH + 1){1'b0}};
  localparam logic [G_DEPTH:0] C_ONE     = {{G_DEPTH{1'b0}}, 1'b1};

  if ((G_DEPTH < 1) || (G_AEMPTY < 0) || (G_AEMPTY >= G_AFULL) || (G_AFULL > C_CAP)) begin : g_bad_params
    $fatal(1, "fifo_sync_flex: illegal G_DEPTH/G_AFULL/G_AEMPTY combination");
  end

  logic [G_WIDTH-1:0] r_mem [C_CAP];
  logic [G_DEPTH:0]   r_wr_ptr;
  logic [G_DEPTH:0]   r_rd_ptr;
  logic [G_DEPTH:0]   w_fill;
  logic               w_full;
  logic               w_empty;
  logic               w_wr_en;
  logic               w_rd_en;

  // Flags decode from registered pointers only; the extra pointer bit disambiguates full from empty.
  assign w_fill  = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_fill == C_CAP_V);
  assign w_empty = (w_fill == C_ZERO);
  assign w_wr_en = i_wr & ~w_full;
  assign w_rd_en = i_rd & ~w_empty;

  assign o_fill_level   = w_fill;
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (w_fill >= C_AFULL_V);
  assign o_almost_empty = (w_fill <= C_AEMPT_V);
  assign o_overflow     = i_wr & w_full;
  assign o_underflow    = i_rd & w_empty;

  // Storage array, deliberately not reset; writes are suppressed while reset is asserted.
  always_ff @(posedge i_clk) begin
    if (w_wr_en && !i_rst) begin
      r_mem[r_wr_ptr[G_DEPTH-1:0]] <= i_data;
    end
  end

  // Write and read pointers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= C_ZERO;
      r_rd_ptr <= C_ZERO;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + C_ONE;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + C_ONE;
      end
    end
  end

  if (G_FWFT != 0) begin : g_fwft
    assign o_data  = r_mem[r_rd_ptr[G_DEPTH-1:0]];
    assign o_valid = ~w_empty;
  end else begin : g_std
    logic [G_WIDTH-1:0] r_data;
    logic               r_valid;

    // Registered read port: data updates only on an accepted read, valid pulses for one cycle.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_data  <= {G_WIDTH{1'b0}};
        r_valid <= 1'b0;
      end else begin
        r_valid <= w_rd_en;
        if (w_rd_en) begin
          r_data <= r_mem[r_rd_ptr[G_DEPTH-1:0]];
        end
      end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
  end

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Bench for fifo_sync_flex: standard-mode instance driven against a queue scoreboard,
// plus a FWFT instance for the fall-through behaviour.
module tb_fifo_sync_flex;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr, rd, f_wr, f_rd;
  logic [7:0] din, f_din;
  logic [7:0] o_data, f_data;
  logic       o_valid, o_full, o_empty, o_afull, o_aempty, o_ovf, o_unf;
  logic       f_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic [4:0] o_fill, f_fill;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] q[$];
  logic       m_valid;
  logic [7:0] m_data;
  logic       s_ovf, s_unf, e_ovf, e_unf;

  always #5 clk = ~clk;

  fifo_sync_flex #(.G_WIDTH(8), .G_DEPTH(4), .G_AFULL(14), .G_AEMPTY(2), .G_FWFT(0)) u_std (
    .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_data(din), .i_rd(rd),
    .o_data(o_data), .o_valid(o_valid), .o_full(o_full), .o_empty(o_empty),
    .o_almost_full(o_afull), .o_almost_empty(o_aempty), .o_fill_level(o_fill),
    .o_overflow(o_ovf), .o_underflow(o_unf)
  );

  fifo_sync_flex #(.G_WIDTH(8), .G_DEPTH(4), .G_AFULL(14), .G_AEMPTY(2), .G_FWFT(1)) u_fwft (
    .i_clk(clk), .i_rst(rst), .i_wr(f_wr), .i_data(f_din), .i_rd(f_rd),
    .o_data(f_data), .o_valid(f_valid), .o_full(f_full), .o_empty(f_empty),
    .o_almost_full(f_afull), .o_almost_empty(f_aempty), .o_fill_level(f_fill),
    .o_overflow(f_ovf), .o_underflow(f_unf)
  );

  // One clock of standard-port stimulus; samples the combinational flags mid-cycle and updates the model.
  task automatic tick(input logic w, input logic [7:0] d, input logic r);
    bit wa, ra;
    wr = w; din = d; rd = r;
    #1;
    s_ovf = o_ovf; s_unf = o_unf;
    e_ovf = w && (q.size() == 16);
    e_unf = r && (q.size() == 0);
    wa = w && (q.size() < 16);
    ra = r && (q.size() > 0);
    @(posedge clk); #1;
    m_valid = ra;
    if (ra) m_data = q.pop_front();
    if (wa) q.push_back(d);
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr = 1'b0; rd = 1'b0; f_wr = 1'b0; f_rd = 1'b0;
    @(posedge clk); #1;
    q.delete(); m_valid = 1'b0; m_data = 8'h00;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_fill !== 5'd0) begin failures++; $display("FAIL rst_fill act=%0d exp=0", o_fill); end
    checks++; if ({o_empty, o_aempty, o_full, o_afull} !== 4'b1100) begin failures++; $display("FAIL rst_flags act=%b exp=1100", {o_empty, o_aempty, o_full, o_afull}); end
    checks++; if (o_valid !== 1'b0 || o_data !== 8'h00) begin failures++; $display("FAIL rst_out act=%b/%h exp=0/00", o_valid, o_data); end
    checks++; if (o_ovf !== 1'b0 || o_unf !== 1'b0) begin failures++; $display("FAIL rst_ovf_unf act=%b%b exp=00", o_ovf, o_unf); end
    rst = 1'b0;
    tick(1'b0, 8'h00, 1'b1);
    checks++; if (s_unf !== 1'b1) begin failures++; $display("FAIL idle_underflow act=%b exp=1", s_unf); end
    checks++; if (o_fill !== 5'd0 || o_empty !== 1'b1 || o_valid !== 1'b0) begin failures++; $display("FAIL idle_rd act=%0d/%b/%b exp=0/1/0", o_fill, o_empty, o_valid); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 8'(i), 1'b0);
      checks++;
      if (o_fill !== 5'(i + 1) || o_afull !== (i + 1 >= 14) || o_aempty !== (i + 1 <= 2) || o_full !== (i == 15) || o_empty !== 1'b0) begin
        failures++; $display("FAIL fill_step%0d act=%0d af=%b ae=%b f=%b e=%b exp=%0d", i, o_fill, o_afull, o_aempty, o_full, o_empty, i + 1);
      end
    end
    tick(1'b1, 8'hEE, 1'b0);
    checks++; if (s_ovf !== 1'b1 || o_fill !== 5'd16) begin failures++; $display("FAIL overflow act=%b/%0d exp=1/16", s_ovf, o_fill); end
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      checks++;
      if (o_valid !== 1'b1 || o_data !== m_data || o_data !== 8'(i) || o_fill !== 5'(15 - i)) begin
        failures++; $display("FAIL drain%0d act=%b/%h/%0d exp=1/%h/%0d", i, o_valid, o_data, o_fill, 8'(i), 15 - i);
      end
    end
    tick(1'b0, 8'h00, 1'b0);
    checks++; if (o_valid !== 1'b0 || o_data !== 8'h0F || o_empty !== 1'b1) begin failures++; $display("FAIL hold act=%b/%h/%b exp=0/0f/1", o_valid, o_data, o_empty); end
  endtask

  task automatic test_back_to_back_wrap();
    for (int i = 0; i < 8; i++) tick(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 8'(8'h80 + i), 1'b1);
      checks++;
      if (o_fill !== 5'd8 || o_valid !== 1'b1 || o_data !== m_data || s_ovf !== e_ovf || s_unf !== e_unf) begin
        failures++; $display("FAIL wrap%0d act=%0d/%b/%h exp=8/1/%h", i, o_fill, o_valid, o_data, m_data);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      checks++; if (o_valid !== 1'b1 || o_data !== m_data) begin failures++; $display("FAIL wrap_drain%0d act=%b/%h exp=1/%h", i, o_valid, o_data, m_data); end
    end
  endtask

  task automatic test_full_empty_both();
    for (int i = 0; i < 16; i++) tick(1'b1, 8'(8'hC0 + i), 1'b0);
    tick(1'b1, 8'h77, 1'b1);
    checks++; if (s_ovf !== 1'b1 || o_fill !== 5'd15 || o_valid !== 1'b1 || o_data !== 8'hC0) begin failures++; $display("FAIL full_both act=%b/%0d/%b/%h exp=1/15/1/c0", s_ovf, o_fill, o_valid, o_data); end
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      checks++; if (o_data !== m_data || o_data !== 8'(8'hC1 + i)) begin failures++; $display("FAIL full_drain%0d act=%h exp=%h", i, o_data, 8'(8'hC1 + i)); end
    end
    tick(1'b1, 8'h5A, 1'b1);
    checks++; if (s_unf !== 1'b1 || o_fill !== 5'd1 || o_valid !== 1'b0) begin failures++; $display("FAIL empty_both act=%b/%0d/%b exp=1/1/0", s_unf, o_fill, o_valid); end
    tick(1'b0, 8'h00, 1'b1);
    checks++; if (o_valid !== 1'b1 || o_data !== 8'h5A || o_data !== m_data) begin failures++; $display("FAIL empty_both_rd act=%b/%h exp=1/5a", o_valid, o_data); end
  endtask

  task automatic test_fwft();
    checks++; if (f_valid !== 1'b0 || f_empty !== 1'b1) begin failures++; $display("FAIL fwft_idle act=%b/%b exp=0/1", f_valid, f_empty); end
    f_wr = 1'b1; f_din = 8'hA5;
    @(posedge clk); #1;
    f_wr = 1'b0;
    checks++; if (f_valid !== 1'b1 || f_data !== 8'hA5 || f_fill !== 5'd1) begin failures++; $display("FAIL fwft_fall act=%b/%h/%0d exp=1/a5/1", f_valid, f_data, f_fill); end
    f_wr = 1'b1; f_din = 8'h3B;
    @(posedge clk); #1;
    f_wr = 1'b0;
    checks++; if (f_data !== 8'hA5 || f_fill !== 5'd2) begin failures++; $display("FAIL fwft_head act=%h/%0d exp=a5/2", f_data, f_fill); end
    f_rd = 1'b1;
    @(posedge clk); #1;
    f_rd = 1'b0;
    checks++; if (f_valid !== 1'b1 || f_data !== 8'h3B) begin failures++; $display("FAIL fwft_next act=%b/%h exp=1/3b", f_valid, f_data); end
    f_rd = 1'b1;
    @(posedge clk); #1;
    f_rd = 1'b0;
    checks++; if (f_valid !== 1'b0 || f_empty !== 1'b1) begin failures++; $display("FAIL fwft_drop act=%b/%b exp=0/1", f_valid, f_empty); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) tick(1'b1, 8'(8'h10 + i), 1'b0);
    checks++; if (o_fill !== 5'd10) begin failures++; $display("FAIL pre_rst_fill act=%0d exp=10", o_fill); end
    tick(1'b0, 8'h00, 1'b1);
    wr = 1'b1; din = 8'h99; rd = 1'b1;
    do_reset();
    checks++; if (o_fill !== 5'd0 || o_empty !== 1'b1 || o_valid !== 1'b0 || o_data !== 8'h00) begin failures++; $display("FAIL mid_rst act=%0d/%b/%b/%h exp=0/1/0/00", o_fill, o_empty, o_valid, o_data); end
    rst = 1'b0;
    tick(1'b1, 8'h3C, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    checks++; if (o_valid !== 1'b1 || o_data !== 8'h3C || o_data !== m_data || o_empty !== 1'b1) begin failures++; $display("FAIL post_rst act=%b/%h/%b exp=1/3c/1", o_valid, o_data, o_empty); end
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; din = 8'h00;
    f_wr = 1'b0; f_rd = 1'b0; f_din = 8'h00;
    m_valid = 1'b0; m_data = 8'h00;
    @(posedge clk); #1;
    test_reset();
    test_fill_drain();
    test_back_to_back_wrap();
    test_full_empty_both();
    test_fwft();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
